control_funcion_conf: RTL and testbench
=======================================

CONTROL_FUNCION_CONF -- requirements
Module: control_funcion_conf

Interface
REQ-001 SHALL have parameter TIMEOUT_CICLOS, default 500_000_000, meaning the number of idle clock cycles before an automatic return to REPOSO.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all flops on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port boton_conf, input, 1 bit: raw mode-advance button, asynchronous to clk.
REQ-005 SHALL have port boton_salir, input, 1 bit: raw exit-configuration button.
REQ-006 SHALL have port boton_der, input, 1 bit: raw next-field button.
REQ-007 SHALL have port boton_izq, input, 1 bit: raw previous-field button.
REQ-008 SHALL have port funcion_conf, output, 2 bits: configuration function code that drives the chip-select register decoder.
REQ-009 SHALL have port campo, output, 2 bits: index of the field being edited within the current function.
REQ-010 SHALL have port en_edicion, output, 1 bit: high whenever funcion_conf != 2'b00.
REQ-011 SHALL have port cambio_modo, output, 1 bit: one-cycle pulse on any funcion_conf change.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer followed by rising-edge detection, giving a 1-cycle pulse per press.
REQ-013 SHALL update registered outputs on the third rising clk edge after the raw input rises.
REQ-014 SHALL implement the FSM with funcion_conf as the state: REPOSO=00, CONF_HORA=01, CONF_FECHA=10, CONF_TIMER=11.
REQ-015 SHALL, on a conf pulse, advance REPOSO->CONF_HORA->CONF_FECHA->CONF_TIMER->REPOSO.
REQ-016 SHALL, on a salir pulse in any state, go to REPOSO; salir wins over a simultaneous conf, der or izq pulse.
REQ-017 SHALL make campo maximum 2 in CONF_HORA and CONF_TIMER, and 3 in CONF_FECHA.
REQ-018 SHALL, on a der pulse, increment campo with wrap from max to 0; on an izq pulse, decrement campo with wrap from 0 to max.
REQ-019 SHALL leave campo unchanged when der and izq pulse in the same cycle.
REQ-020 SHALL clear campo to 0 on every state change; a conf pulse takes priority over der/izq in the same cycle.
REQ-021 SHALL hold campo at 0 in REPOSO and ignore der and izq there.
REQ-022 SHALL use a timeout counter of ceil(log2(TIMEOUT_CICLOS)) bits, held at 0 in REPOSO and cleared by any button pulse.
REQ-023 SHALL otherwise increment the timeout counter by 1 per cycle in non-REPOSO states.
REQ-024 SHALL, when the counter equals TIMEOUT_CICLOS-1, enter REPOSO on the next edge and clear the counter; a pulse in that same cycle cancels the timeout.
REQ-025 SHALL register en_edicion and cambio_modo, aligned with the funcion_conf update.
REQ-026 SHALL assert cambio_modo for exactly one cycle per state change, including timeout and salir transitions.
REQ-027 SHALL produce no cambio_modo for salir pressed while already in REPOSO.

Reset
REQ-028 SHALL, while reset_n=0, asynchronously force funcion_conf=00, campo=00, en_edicion=0, cambio_modo=0, timeout counter=0, and all synchronizer and edge flops=0.
REQ-029 SHALL treat a button held high through reset release as not pressed; a pulse requires a new 0->1 transition.
REQ-030 SHALL, when reset asserts mid-configuration, abandon the state immediately with no cambio_modo pulse.

Structure
REQ-031 SHALL place the state encodings REPOSO, CONF_HORA, CONF_FECHA and CONF_TIMER plus the constants CAMPO_MAX_HORA=2, CAMPO_MAX_FECHA=3 and CAMPO_MAX_TIMER=2 in the shared project constants file, also used by the chip-select decoder.
REQ-032 SHALL implement the per-button logic as sub-module sincronizador_boton (clk, reset_n, boton_in, pulso_out), instantiated four times.

Verification (bench TIMEOUT_CICLOS=16)
REQ-033 SHALL verify: four separate conf presses -> funcion_conf 01, 10, 11, 00, each valid 3 edges after press, with 4 cambio_modo pulses.
REQ-034 SHALL verify: in CONF_FECHA, der x4 -> campo 1, 2, 3, 0; then izq x1 -> campo 3; then der and izq together -> campo stays 3.
REQ-035 SHALL verify: in CONF_HORA, no presses for 16 cycles -> funcion_conf=00, en_edicion=0 and one cambio_modo pulse; a der press at count 15 -> no timeout.
REQ-036 SHALL verify: in CONF_TIMER with campo=2, salir and conf pressed together -> funcion_conf=00 and campo=00.
REQ-037 SHALL verify: boton_conf held high across reset_n release -> funcion_conf stays 00 until the button drops and rises again.
REQ-038 SHALL verify: reset_n pulled low mid-cycle in CONF_FECHA with campo=2 -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/control_funcion_conf_pkg.sv
// Shared constants for the configuration-mode controller and the chip-select
// register decoder.
//   funcion_e        : configuration function code; it is also the FSM state.
//   CAMPO_MAX_*      : highest editable field index for each function.
//   campo_max()      : maps a function code to its highest field index.
package control_funcion_conf_pkg;

    typedef enum logic [1:0] {
        REPOSO     = 2'b00,
        CONF_HORA  = 2'b01,
        CONF_FECHA = 2'b10,
        CONF_TIMER = 2'b11
    } funcion_e;

    localparam logic [1:0] CAMPO_MAX_HORA  = 2'd2;
    localparam logic [1:0] CAMPO_MAX_FECHA = 2'd3;
    localparam logic [1:0] CAMPO_MAX_TIMER = 2'd2;

    function automatic logic [1:0] campo_max(input funcion_e f);
        case (f)
            CONF_HORA:  campo_max = CAMPO_MAX_HORA;
            CONF_FECHA: campo_max = CAMPO_MAX_FECHA;
            CONF_TIMER: campo_max = CAMPO_MAX_TIMER;
            default:    campo_max = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/control_funcion_conf_if.sv
// Pin bundle of the configuration-mode controller.
//   boton_*      : raw buttons (conf, salir, der, izq), asynchronous to clk.
//   funcion_conf : current configuration function (FSM state).
//   campo        : field being edited within the current function.
//   en_edicion   : high whenever funcion_conf is not REPOSO.
//   cambio_modo  : one-cycle pulse on each funcion_conf change.
// master drives the buttons and observes the results; slave is the device.
interface control_funcion_conf_if;
    logic       boton_conf;
    logic       boton_salir;
    logic       boton_der;
    logic       boton_izq;
    logic [1:0] funcion_conf;
    logic [1:0] campo;
    logic       en_edicion;
    logic       cambio_modo;

    modport master (
        output boton_conf, boton_salir, boton_der, boton_izq,
        input  funcion_conf, campo, en_edicion, cambio_modo
    );

    modport slave (
        input  boton_conf, boton_salir, boton_der, boton_izq,
        output funcion_conf, campo, en_edicion, cambio_modo
    );
endinterface

// File: rtl/control_funcion_conf_sincronizador_boton.sv
// Button conditioner: 2-flop synchronizer plus rising-edge detector.
//   clk, reset_n : clock, asynchronous active-low reset.
//   boton_in     : raw button level.
//   pulso_out    : one-cycle pulse for each 0->1 transition of the button.
// A button already high when reset releases must first be seen low before a
// press is accepted; armado_q records that, once the synchronizer holds a
// real sample (vld_q tracks the two flush cycles after reset).
module sincronizador_boton (
    input  logic clk,
    input  logic reset_n,
    input  logic boton_in,
    output logic pulso_out
);
    logic       sinc1_q;
    logic       sinc2_q;
    logic       prev_q;
    logic       armado_q;
    logic [1:0] vld_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sinc1_q  <= 1'b0;
            sinc2_q  <= 1'b0;
            prev_q   <= 1'b0;
            armado_q <= 1'b0;
            vld_q    <= 2'b00;
        end else begin
            sinc1_q  <= boton_in;
            sinc2_q  <= sinc1_q;
            prev_q   <= sinc2_q;
            vld_q    <= {vld_q[0], 1'b1};
            armado_q <= armado_q | (vld_q[1] & ~sinc2_q);
        end
    end

    assign pulso_out = sinc2_q & ~prev_q & armado_q;

endmodule

// File: rtl/control_funcion_conf.sv
// Configuration-mode controller: steps through REPOSO/CONF_HORA/CONF_FECHA/
// CONF_TIMER on button presses, tracks the edited field and falls back to
// REPOSO after TIMEOUT_CICLOS idle cycles.
//   clk, reset_n      : clock, asynchronous active-low reset.
//   boton_conf/salir/der/izq : raw buttons.
//   funcion_conf      : function code (FSM state), registered.
//   campo             : edited field index, registered.
//   en_edicion        : registered, high outside REPOSO.
//   cambio_modo       : registered one-cycle pulse per state change.
// A raw press reaches the outputs on the third clk edge: two synchronizer
// edges, then the FSM register edge.
module control_funcion_conf
    import control_funcion_conf_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = 500_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       boton_conf,
    input  logic       boton_salir,
    input  logic       boton_der,
    input  logic       boton_izq,
    output logic [1:0] funcion_conf,
    output logic [1:0] campo,
    output logic       en_edicion,
    output logic       cambio_modo
);
    localparam int CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(TIMEOUT_CICLOS - 1);

    logic p_conf, p_salir, p_der, p_izq, any_pulse;

    sincronizador_boton u_conf  (.clk(clk), .reset_n(reset_n), .boton_in(boton_conf),  .pulso_out(p_conf));
    sincronizador_boton u_salir (.clk(clk), .reset_n(reset_n), .boton_in(boton_salir), .pulso_out(p_salir));
    sincronizador_boton u_der   (.clk(clk), .reset_n(reset_n), .boton_in(boton_der),   .pulso_out(p_der));
    sincronizador_boton u_izq   (.clk(clk), .reset_n(reset_n), .boton_in(boton_izq),   .pulso_out(p_izq));

    funcion_e         state_q, state_d;
    logic [1:0]       campo_q, campo_d, max_campo;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, cambio_q;

    assign any_pulse = p_conf | p_salir | p_der | p_izq;

    always_comb begin
        // salir beats conf; any pulse in the timeout cycle cancels the timeout.
        state_d = state_q;
        if (p_salir)
            state_d = REPOSO;
        else if (p_conf)
            state_d = funcion_e'(state_q + 2'd1);
        else if (state_q != REPOSO && !any_pulse && cnt_q == CNT_FIN)
            state_d = REPOSO;

        max_campo = campo_max(state_q);
        campo_d   = campo_q;
        if (state_d != state_q || state_q == REPOSO)
            campo_d = 2'd0;
        else if (p_der && !p_izq)
            campo_d = (campo_q == max_campo) ? 2'd0 : campo_q + 2'd1;
        else if (p_izq && !p_der)
            campo_d = (campo_q == 2'd0) ? max_campo : campo_q - 2'd1;

        cnt_d = (state_d == REPOSO || any_pulse) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= REPOSO;
            campo_q  <= 2'd0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            cambio_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            campo_q  <= campo_d;
            cnt_q    <= cnt_d;
            en_q     <= (state_d != REPOSO);
            cambio_q <= (state_d != state_q);
        end
    end

    assign funcion_conf = state_q;
    assign campo        = campo_q;
    assign en_edicion   = en_q;
    assign cambio_modo  = cambio_q;

endmodule

// File: tb/tb_control_funcion_conf.sv
// Directed bench for control_funcion_conf with TIMEOUT_CICLOS=16.
module tb_control_funcion_conf;
    import control_funcion_conf_pkg::*;

    localparam int unsigned T = 16;
    localparam int B_CONF  = 0;
    localparam int B_SALIR = 1;
    localparam int B_DER   = 2;
    localparam int B_IZQ   = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    control_funcion_conf_if bus();

    control_funcion_conf #(.TIMEOUT_CICLOS(T)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .boton_conf   (bus.boton_conf),
        .boton_salir  (bus.boton_salir),
        .boton_der    (bus.boton_der),
        .boton_izq    (bus.boton_izq),
        .funcion_conf (bus.funcion_conf),
        .campo        (bus.campo),
        .en_edicion   (bus.en_edicion),
        .cambio_modo  (bus.cambio_modo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_cambio = 0;

    // cambio_modo pulses seen, sampled mid-cycle
    always @(negedge clk) if (bus.cambio_modo === 1'b1) n_cambio++;

    logic [1:0] exp_f [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] exp_c [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] f, input logic [1:0] c,
                              input logic en, input logic cm);
        check_eq({tag, "_funcion"}, 32'(bus.funcion_conf), 32'(f));
        check_eq({tag, "_campo"},   32'(bus.campo),        32'(c));
        check_eq({tag, "_en"},      32'(bus.en_edicion),   32'(en));
        check_eq({tag, "_cambio"},  32'(bus.cambio_modo),  32'(cm));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            B_CONF:  bus.boton_conf  = v;
            B_SALIR: bus.boton_salir = v;
            B_DER:   bus.boton_der   = v;
            default: bus.boton_izq   = v;
        endcase
    endtask

    task automatic raise(input int idx);
        @(negedge clk);
        set_btn(idx, 1'b1);
    endtask

    // raw rise, then the third edge updates the outputs
    task automatic press(input int idx);
        raise(idx);
        tick(3);
    endtask

    task automatic release_all();
        @(negedge clk);
        bus.boton_conf  = 1'b0;
        bus.boton_salir = 1'b0;
        bus.boton_der   = 1'b0;
        bus.boton_izq   = 1'b0;
        tick(3);
    endtask

    initial begin
        int c0;
        logic [1:0] prev;
        bus.boton_conf  = 1'b0;
        bus.boton_salir = 1'b0;
        bus.boton_der   = 1'b0;
        bus.boton_izq   = 1'b0;

        // reset state
        tick(3);
        check_outs("reset", 2'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(4);

        // conf cycles through all four functions, 3-edge latency
        prev = 2'd0;
        for (int i = 0; i < 4; i++) begin
            raise(B_CONF);
            tick(2);
            check_eq("conf_latency", 32'(bus.funcion_conf), 32'(prev));
            tick(1);
            check_outs("conf_step", exp_f[i], 2'd0, exp_f[i] != 2'd0, 1'b1);
            prev = exp_f[i];
            release_all();
        end
        check_eq("conf_cambio_count", n_cambio, 4);

        // field navigation in CONF_FECHA
        press(B_CONF); release_all();
        press(B_CONF); release_all();
        check_eq("fecha_state", 32'(bus.funcion_conf), 32'(CONF_FECHA));
        for (int i = 0; i < 4; i++) begin
            press(B_DER);
            check_eq("der_wrap", 32'(bus.campo), 32'(exp_c[i]));
            release_all();
        end
        press(B_IZQ);
        check_eq("izq_wrap", 32'(bus.campo), 32'd3);
        release_all();
        @(negedge clk);
        bus.boton_der = 1'b1;
        bus.boton_izq = 1'b1;
        tick(3);
        check_outs("der_izq_both", 2'd2, 2'd3, 1'b1, 1'b0);
        release_all();

        // CONF_TIMER, campo=2, salir+conf together
        press(B_CONF);
        check_outs("timer_entry", 2'd3, 2'd0, 1'b1, 1'b1);
        release_all();
        press(B_IZQ);
        check_eq("timer_izq_wrap", 32'(bus.campo), 32'd2);
        release_all();
        @(negedge clk);
        bus.boton_salir = 1'b1;
        bus.boton_conf  = 1'b1;
        tick(3);
        check_outs("salir_wins", 2'd0, 2'd0, 1'b0, 1'b1);
        release_all();
        c0 = n_cambio;
        press(B_SALIR);
        release_all();
        check_eq("salir_in_reposo", n_cambio, c0);

        // timeout after 16 idle cycles in CONF_HORA
        c0 = n_cambio;
        press(B_CONF);
        @(negedge clk);
        bus.boton_conf = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check_eq("timeout_pre", 32'(bus.funcion_conf), 32'(CONF_HORA));
        tick(1);
        check_outs("timeout", 2'd0, 2'd0, 1'b0, 1'b1);
        tick(1);
        check_eq("timeout_cambio_count", n_cambio, c0 + 2);

        // der pulse in the count=15 cycle cancels the timeout
        press(B_CONF);
        @(negedge clk);
        bus.boton_conf = 1'b0;
        repeat (13) @(posedge clk);
        @(negedge clk);
        bus.boton_der = 1'b1;
        tick(3);
        check_outs("timeout_cancel", 2'd1, 2'd1, 1'b1, 1'b0);
        tick(2);
        check_eq("timeout_cancel_hold", 32'(bus.funcion_conf), 32'(CONF_HORA));
        @(negedge clk);
        bus.boton_der = 1'b0;
        press(B_SALIR);
        check_eq("hora_salir", 32'(bus.funcion_conf), 32'(REPOSO));
        release_all();

        // conf held through reset release is not a press
        @(negedge clk);
        reset_n = 1'b0;
        bus.boton_conf = 1'b1;
        tick(2);
        @(negedge clk);
        reset_n = 1'b1;
        tick(6);
        check_eq("held_through_reset", 32'(bus.funcion_conf), 32'(REPOSO));
        @(negedge clk);
        bus.boton_conf = 1'b0;
        tick(3);
        check_eq("held_dropped", 32'(bus.funcion_conf), 32'(REPOSO));
        press(B_CONF);
        check_eq("held_new_press", 32'(bus.funcion_conf), 32'(CONF_HORA));
        release_all();

        // async reset mid-cycle in CONF_FECHA with campo=2
        press(B_CONF); release_all();
        press(B_DER);  release_all();
        press(B_DER);  release_all();
        check_eq("pre_reset_funcion", 32'(bus.funcion_conf), 32'(CONF_FECHA));
        check_eq("pre_reset_campo", 32'(bus.campo), 32'd2);
        c0 = n_cambio;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_outs("async_reset", 2'd0, 2'd0, 1'b0, 1'b0);
        tick(2);
        check_eq("reset_no_cambio", n_cambio, c0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
